// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 matrix keypad scanner with debounce and single-key lockout
module keypad_scanner #(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst,
    output logic [3:0] row,
    input  logic [3:0] col,
    output logic       keydown_num,
    output logic       keydown_start,
    output logic       keydown_clear,
    output logic       keydown_confirm,
    output logic [3:0] num
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int DB_W  = $clog2(DEBOUNCE_SCANS + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DB_W-1:0]  DB_FULL  = DB_W'(DEBOUNCE_SCANS);

    // Scan codes: 0..15 are single key indices, bit 4 marks the non-key results.
    localparam logic [4:0] CODE_NONE  = 5'd16;
    localparam logic [4:0] CODE_MULTI = 5'd17;

    // Key indices that drive a dedicated keydown output.
    localparam logic [3:0] IDX_START   = 4'd3;
    localparam logic [3:0] IDX_CLEAR   = 4'd7;
    localparam logic [3:0] IDX_CONFIRM = 4'd11;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    // Digit keys: 1 2 3 / 4 5 6 / 7 8 9 / 0 at row 3 col 1.
    function automatic logic is_digit(input logic [3:0] idx);
        case (idx)
            4'd0, 4'd1, 4'd2,
            4'd4, 4'd5, 4'd6,
            4'd8, 4'd9, 4'd10,
            4'd13:   is_digit = 1'b1;
            default: is_digit = 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] digit_of(input logic [3:0] idx);
        case (idx)
            4'd0:    digit_of = 4'd1;
            4'd1:    digit_of = 4'd2;
            4'd2:    digit_of = 4'd3;
            4'd4:    digit_of = 4'd4;
            4'd5:    digit_of = 4'd5;
            4'd6:    digit_of = 4'd6;
            4'd8:    digit_of = 4'd7;
            4'd9:    digit_of = 4'd8;
            4'd10:   digit_of = 4'd9;
            default: digit_of = 4'd0;
        endcase
    endfunction

    // Keys that produce an output; everything else (*, #, D) only blocks others.
    function automatic logic is_active_key(input logic [3:0] idx);
        is_active_key = is_digit(idx) || (idx == IDX_START) ||
                        (idx == IDX_CLEAR) || (idx == IDX_CONFIRM);
    endfunction

    logic [3:0]       col_meta;
    logic [3:0]       col_sync;
    logic [DIV_W-1:0] div_cnt;
    logic [1:0]       row_idx;
    logic             sample;
    logic             scan_done;

    logic [3:0]       low_bits;
    logic [2:0]       row_cnt;
    logic [1:0]       col_idx;
    logic [1:0]       acc_cnt;
    logic [3:0]       acc_idx;
    logic [3:0]       sum_cnt;
    logic [1:0]       merged_cnt;
    logic [3:0]       merged_idx;
    logic [4:0]       scan_result;

    logic [4:0]       prev_result;
    logic [DB_W-1:0]  db_cnt;
    logic [DB_W-1:0]  db_next;
    logic [4:0]       stable;

    state_t           state;
    state_t           state_next;
    logic             accept;
    logic [3:0]       held;
    logic             hold_ok;

    // Two-flop synchronizer for the asynchronous column inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_meta <= 4'hf;
            col_sync <= 4'hf;
        end else begin
            col_meta <= col;
            col_sync <= col_meta;
        end
    end

    assign sample    = (div_cnt == DIV_LAST);
    assign scan_done = sample && (row_idx == 2'd3);

    // Row timer: each row stays low for SCAN_DIV cycles, then the drive rotates.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            row_idx <= 2'd0;
            row     <= 4'b1110;
        end else if (sample) begin
            div_cnt <= '0;
            row_idx <= row_idx + 2'd1;
            row     <= {row[2:0], row[3]};
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Fold this row's sampled columns into the running per-scan result.
    always_comb begin
        low_bits   = ~col_sync;
        row_cnt    = {2'b00, low_bits[0]} + {2'b00, low_bits[1]} +
                     {2'b00, low_bits[2]} + {2'b00, low_bits[3]};
        col_idx    = 2'd0;
        if (low_bits[3]) col_idx = 2'd3;
        if (low_bits[2]) col_idx = 2'd2;
        if (low_bits[1]) col_idx = 2'd1;
        if (low_bits[0]) col_idx = 2'd0;
        sum_cnt    = {2'b00, acc_cnt} + {1'b0, row_cnt};
        merged_cnt = (sum_cnt >= 4'd2) ? 2'd2 : sum_cnt[1:0];
        merged_idx = acc_idx;
        if (acc_cnt == 2'd0 && row_cnt != 3'd0) begin
            merged_idx = {row_idx, col_idx};
        end
        scan_result = CODE_MULTI;
        if (merged_cnt == 2'd0) begin
            scan_result = CODE_NONE;
        end else if (merged_cnt == 2'd1) begin
            scan_result = {1'b0, merged_idx};
        end
    end

    // Per-scan accumulator: count of low bits (saturating at 2) and first key index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_cnt <= 2'd0;
            acc_idx <= 4'd0;
        end else if (scan_done) begin
            acc_cnt <= 2'd0;
            acc_idx <= 4'd0;
        end else if (sample) begin
            acc_cnt <= merged_cnt;
            acc_idx <= merged_idx;
        end
    end

    // A differing result restarts the run; an identical one extends it up to full.
    always_comb begin
        db_next = DB_W'(1);
        if (scan_result == prev_result) begin
            db_next = (db_cnt == DB_FULL) ? DB_FULL : db_cnt + 1'b1;
        end
    end

    // Debounce: stable only follows a result seen DEBOUNCE_SCANS scans in a row.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_result <= CODE_NONE;
            db_cnt      <= '0;
            stable      <= CODE_NONE;
        end else if (scan_done) begin
            prev_result <= scan_result;
            db_cnt      <= db_next;
            if (db_next == DB_FULL) begin
                stable <= scan_result;
            end
        end
    end

    // Output FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Output FSM: accept a lone key from IDLE, lock out on any second or ignored key.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (stable == CODE_NONE) begin
                    state_next = IDLE;
                end else if (stable[4] || !is_active_key(stable[3:0])) begin
                    state_next = LOCKED;
                end else begin
                    accept     = 1'b1;
                    state_next = PRESSED;
                end
            end
            PRESSED: begin
                if (stable == CODE_NONE) begin
                    state_next = IDLE;
                end else if (stable != {1'b0, held}) begin
                    state_next = LOCKED;
                end
            end
            LOCKED: begin
                if (stable == CODE_NONE) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Capture the accepted key; num updates here, a cycle ahead of keydown_num.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            held <= 4'd0;
            num  <= 4'd0;
        end else if (accept) begin
            held <= stable[3:0];
            if (is_digit(stable[3:0])) begin
                num <= digit_of(stable[3:0]);
            end
        end
    end

    assign hold_ok = (state == PRESSED) && (stable == {1'b0, held});

    // Registered keydown levels: glitch-free and mutually exclusive via held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            keydown_num     <= 1'b0;
            keydown_start   <= 1'b0;
            keydown_clear   <= 1'b0;
            keydown_confirm <= 1'b0;
        end else begin
            keydown_num     <= hold_ok && is_digit(held);
            keydown_start   <= hold_ok && (held == IDX_START);
            keydown_clear   <= hold_ok && (held == IDX_CLEAR);
            keydown_confirm <= hold_ok && (held == IDX_CONFIRM);
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - scoreboard bench for keypad_scanner
module tb_keypad_scanner;

    logic       clk;
    logic       rst;
    logic [3:0] row;
    logic [3:0] col;
    logic       keydown_num;
    logic       keydown_start;
    logic       keydown_clear;
    logic       keydown_confirm;
    logic [3:0] num;

    logic [15:0] pressed;
    int          total;
    int          bad;
    logic [7:0]  sb[$];
    logic [3:0]  kd_prev;
    logic [3:0]  num_prev;
    logic        multi_seen;

    localparam logic [3:0] M_NUM     = 4'b0001;
    localparam logic [3:0] M_START   = 4'b0010;
    localparam logic [3:0] M_CLEAR   = 4'b0100;
    localparam logic [3:0] M_CONFIRM = 4'b1000;

    keypad_scanner #(
        .SCAN_DIV       (4),
        .DEBOUNCE_SCANS (3)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .row             (row),
        .col             (col),
        .keydown_num     (keydown_num),
        .keydown_start   (keydown_start),
        .keydown_clear   (keydown_clear),
        .keydown_confirm (keydown_confirm),
        .num             (num)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        col = 4'hf;
        for (int r = 0; r < 4; r++) begin
            if (!row[r]) begin
                for (int c = 0; c < 4; c++) begin
                    if (pressed[4*r + c]) col[c] = 1'b0;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_rise(input logic [3:0] mask, input logic [3:0] n);
        sb.push_back({mask, n});
    endtask

    always @(negedge clk) begin
        logic [3:0] kd;
        logic [3:0] rises;
        logic [7:0] e;
        kd = {keydown_confirm, keydown_clear, keydown_start, keydown_num};
        if (!rst) begin
            if ($countones(kd) > 1) multi_seen = 1'b1;
            rises = kd & ~kd_prev;
            if (rises != 4'd0) begin
                if (sb.size() == 0) begin
                    chk("spurious_rise", {28'd0, rises}, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("rise_kind", {28'd0, rises}, {28'd0, e[7:4]});
                    chk("num_at_rise", {28'd0, num}, {28'd0, e[3:0]});
                    chk("num_before_rise", {28'd0, num_prev}, {28'd0, e[3:0]});
                end
            end
        end
        kd_prev  = kd;
        num_prev = num;
    end

    initial begin
        int lat;
        total      = 0;
        bad        = 0;
        multi_seen = 1'b0;
        kd_prev    = 4'd0;
        num_prev   = 4'd0;
        pressed    = 16'd0;
        rst        = 1'b1;
        wait_n(3);
        chk("reset_row", {28'd0, row}, 32'h0000000e);
        chk("reset_kd", {28'd0, keydown_confirm, keydown_clear, keydown_start, keydown_num}, 32'd0);
        chk("reset_num", {28'd0, num}, 32'd0);
        rst = 1'b0;
        wait_n(40);

        // A then C: function keys, num stays at reset value
        expect_rise(M_START, 4'd0);
        pressed[3] = 1'b1;
        wait_n(100);
        chk("start_held", {31'd0, keydown_start}, 32'd1);
        pressed[3] = 1'b0;
        wait_n(100);
        chk("start_released", {31'd0, keydown_start}, 32'd0);
        expect_rise(M_CONFIRM, 4'd0);
        pressed[11] = 1'b1;
        wait_n(100);
        chk("confirm_held", {31'd0, keydown_confirm}, 32'd1);
        chk("num_after_ac", {28'd0, num}, 32'd0);
        pressed[11] = 1'b0;
        wait_n(100);

        // Key 7 with latency window
        expect_rise(M_NUM, 4'd7);
        pressed[8] = 1'b1;
        lat = 0;
        while (!keydown_num && lat < 150) begin
            @(negedge clk);
            lat++;
        end
        chk("lat7_in_window", {31'd0, (lat >= 16 && lat <= 68)}, 32'd1);
        wait_n(20);
        pressed[8] = 1'b0;
        wait_n(100);
        chk("num7_release_kd", {31'd0, keydown_num}, 32'd0);
        chk("num7_hold_value", {28'd0, num}, 32'd7);

        // Key 5 bouncing, then steady: exactly one acceptance
        expect_rise(M_NUM, 4'd5);
        for (int i = 0; i < 8; i++) begin
            pressed[5] = ~pressed[5];
            wait_n(8);
        end
        pressed[5] = 1'b1;
        wait_n(120);
        chk("key5_held", {31'd0, keydown_num}, 32'd1);
        pressed[5] = 1'b0;
        wait_n(100);

        // Hold 1, add 2 -> lockout until full release, then 3 accepted
        expect_rise(M_NUM, 4'd1);
        pressed[0] = 1'b1;
        wait_n(100);
        pressed[1] = 1'b1;
        wait_n(100);
        chk("multi_drop", {31'd0, keydown_num}, 32'd0);
        pressed[1] = 1'b0;
        wait_n(100);
        chk("locked_kd", {28'd0, keydown_confirm, keydown_clear, keydown_start, keydown_num}, 32'd0);
        pressed[0] = 1'b0;
        wait_n(100);
        expect_rise(M_NUM, 4'd3);
        pressed[2] = 1'b1;
        wait_n(100);
        chk("key3_num", {28'd0, num}, 32'd3);
        pressed[2] = 1'b0;
        wait_n(100);

        // Ignored key # then 9: no output until full release, then 9 alone accepted
        pressed[14] = 1'b1;
        wait_n(100);
        pressed[10] = 1'b1;
        wait_n(100);
        chk("ignored_no_kd", {28'd0, keydown_confirm, keydown_clear, keydown_start, keydown_num}, 32'd0);
        pressed[14] = 1'b0;
        pressed[10] = 1'b0;
        wait_n(100);
        chk("ignored_num_kept", {28'd0, num}, 32'd3);
        expect_rise(M_NUM, 4'd9);
        pressed[10] = 1'b1;
        wait_n(100);
        chk("key9_num", {28'd0, num}, 32'd9);
        pressed[10] = 1'b0;
        wait_n(100);

        // Reset while B held: immediate clear, then re-detection
        expect_rise(M_CLEAR, 4'd9);
        pressed[7] = 1'b1;
        wait_n(100);
        chk("clear_held", {31'd0, keydown_clear}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_kd_clear", {31'd0, keydown_clear}, 32'd0);
        chk("rst_row", {28'd0, row}, 32'h0000000e);
        chk("rst_num", {28'd0, num}, 32'd0);
        wait_n(3);
        expect_rise(M_CLEAR, 4'd0);
        rst = 1'b0;
        wait_n(100);
        chk("clear_again", {31'd0, keydown_clear}, 32'd1);
        pressed[7] = 1'b0;
        wait_n(100);
        chk("clear_released", {31'd0, keydown_clear}, 32'd0);

        chk("onehot", {31'd0, multi_seen}, 32'd0);
        chk("sb_empty", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
